// File: rtl/insight_commit_collector.sv
// insight_commit_collector: buffers up to two commit records per cycle in program order and streams them out one per cycle
module insight_commit_collector #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 39,
  parameter int XLEN  = 64,
  parameter int SEQ_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_c0_valid,
  input  logic [PC_W-1:0]            i_c0_pc,
  input  logic [31:0]                i_c0_insn,
  input  logic                       i_c0_wen,
  input  logic [4:0]                 i_c0_rd,
  input  logic [XLEN-1:0]            i_c0_wdata,
  input  logic                       i_c0_exc,
  input  logic                       i_c1_valid,
  input  logic [PC_W-1:0]            i_c1_pc,
  input  logic [31:0]                i_c1_insn,
  input  logic                       i_c1_wen,
  input  logic [4:0]                 i_c1_rd,
  input  logic [XLEN-1:0]            i_c1_wdata,
  input  logic                       i_c1_exc,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [PC_W-1:0]            o_out_pc,
  output logic [31:0]                o_out_insn,
  output logic                       o_out_wen,
  output logic [4:0]                 o_out_rd,
  output logic [XLEN-1:0]            o_out_wdata,
  output logic                       o_out_exc,
  output logic [SEQ_W-1:0]           o_out_seq,
  output logic                       o_out_gap,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [CNT_W-1:0]           o_drop_count,
  output logic                       o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = PC_W + 32 + 1 + 5 + XLEN + 1 + SEQ_W + 1;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_head, r_tail;
  logic [LW-1:0]    r_level;
  logic [SEQ_W-1:0] r_seq;
  logic             r_gap, r_overflow;
  logic [CNT_W-1:0] r_drop;
  logic [1:0]       w_n;
  logic [LW-1:0]    w_free;
  logic             w_acc, w_drop, w_deq;
  logic [EW-1:0]    w_ent_a, w_ent_b;
  logic [CNT_W:0]   w_dsum;
  // Free space comes from the registered level only, so a same-cycle dequeue never makes room
  assign w_n     = {1'b0, i_c0_valid} + {1'b0, i_c1_valid};
  assign w_free  = LW'(DEPTH) - r_level;
  assign w_acc   = (w_n != 2'd0) && (LW'(w_n) <= w_free);
  assign w_drop  = (w_n != 2'd0) && !w_acc;
  assign w_deq   = (r_level != '0) && i_out_ready;
  assign w_dsum  = {1'b0, r_drop} + (CNT_W+1)'(w_n);
  // A lone slot-1 commit is the older (first) record of the cycle
  assign w_ent_a = i_c0_valid ? {i_c0_pc, i_c0_insn, i_c0_wen, i_c0_rd, i_c0_wdata, i_c0_exc, r_seq, r_gap}
                              : {i_c1_pc, i_c1_insn, i_c1_wen, i_c1_rd, i_c1_wdata, i_c1_exc, r_seq, r_gap};
  assign w_ent_b = {i_c1_pc, i_c1_insn, i_c1_wen, i_c1_rd, i_c1_wdata, i_c1_exc, r_seq + SEQ_W'(1), 1'b0};
  assign o_out_valid  = r_level != '0;
  assign {o_out_pc, o_out_insn, o_out_wen, o_out_rd, o_out_wdata, o_out_exc, o_out_seq, o_out_gap} = r_mem[r_head];
  assign o_level      = r_level;
  assign o_drop_count = r_drop;
  assign o_overflow   = r_overflow;
  // Accepted records are written at the tail in program order; contents need no reset
  always_ff @(posedge i_clock) begin
    if (w_acc) begin
      r_mem[r_tail] <= w_ent_a;
      if (w_n == 2'd2) r_mem[r_tail + AW'(1)] <= w_ent_b;
    end
  end
  // Pointers, occupancy, sequence numbering and drop bookkeeping
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_level    <= '0;
      r_seq      <= '0;
      r_gap      <= 1'b0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_acc) r_tail <= r_tail + AW'(w_n);
      if (w_deq) r_head <= r_head + AW'(1);
      r_level <= r_level + LW'(w_acc ? w_n : 2'd0) - LW'(w_deq);
      if (w_n != 2'd0) r_seq <= r_seq + SEQ_W'(w_n);
      if (w_drop) r_gap <= 1'b1;
      else if (w_acc) r_gap <= 1'b0;
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_drop     <= w_dsum[CNT_W] ? '1 : w_dsum[CNT_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_insight_commit_collector.sv
// tb_insight_commit_collector: scoreboard bench for the commit collector
module tb_insight_commit_collector;
  typedef struct packed {
    logic [38:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic        exc;
    logic [15:0] seq;
    logic        gap;
  } rec_t;
  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_c0_valid = 1'b0, i_c1_valid = 1'b0;
  logic [38:0] i_c0_pc = '0, i_c1_pc = '0;
  logic [31:0] i_c0_insn = '0, i_c1_insn = '0;
  logic        i_c0_wen = 1'b0, i_c1_wen = 1'b0;
  logic [4:0]  i_c0_rd = '0, i_c1_rd = '0;
  logic [63:0] i_c0_wdata = '0, i_c1_wdata = '0;
  logic        i_c0_exc = 1'b0, i_c1_exc = 1'b0;
  logic        i_out_ready = 1'b0;
  logic        o_out_valid;
  logic [38:0] o_out_pc;
  logic [31:0] o_out_insn;
  logic        o_out_wen;
  logic [4:0]  o_out_rd;
  logic [63:0] o_out_wdata;
  logic        o_out_exc;
  logic [15:0] o_out_seq;
  logic        o_out_gap;
  logic [3:0]  o_level;
  logic [15:0] o_drop_count;
  logic        o_overflow;
  int          checks = 0;
  int          errors = 0;
  rec_t        q[$];
  logic [15:0] m_seq = '0;
  logic        m_gap = 1'b0;
  logic        m_ovf = 1'b0;
  int          m_drop = 0;
  int          popped = 0;
  logic [15:0] last_seq = '0, prev_seq = '0;
  logic        last_gap = 1'b0;
  int          lvl, n;
  rec_t        e, a, b;
  insight_commit_collector #(.DEPTH(8), .PC_W(39), .XLEN(64), .SEQ_W(16), .CNT_W(16)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_c0_valid(i_c0_valid), .i_c0_pc(i_c0_pc), .i_c0_insn(i_c0_insn), .i_c0_wen(i_c0_wen),
    .i_c0_rd(i_c0_rd), .i_c0_wdata(i_c0_wdata), .i_c0_exc(i_c0_exc),
    .i_c1_valid(i_c1_valid), .i_c1_pc(i_c1_pc), .i_c1_insn(i_c1_insn), .i_c1_wen(i_c1_wen),
    .i_c1_rd(i_c1_rd), .i_c1_wdata(i_c1_wdata), .i_c1_exc(i_c1_exc),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_pc(o_out_pc), .o_out_insn(o_out_insn), .o_out_wen(o_out_wen), .o_out_rd(o_out_rd),
    .o_out_wdata(o_out_wdata), .o_out_exc(o_out_exc), .o_out_seq(o_out_seq), .o_out_gap(o_out_gap),
    .o_level(o_level), .o_drop_count(o_drop_count), .o_overflow(o_overflow)
  );
  always #5 clk = ~clk;
  // Reference model and scoreboard, evaluated mid-cycle with stable inputs and outputs
  always @(negedge clk) begin
    if (!i_reset) begin
      q.delete();
      m_seq = '0;
      m_gap = 1'b0;
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      lvl = q.size();
      checks++;
      if (o_out_valid !== (lvl != 0)) begin
        errors++;
        $display("FAIL out_valid: got %b want %b", o_out_valid, lvl != 0);
      end
      checks++;
      if (o_level !== 4'(lvl)) begin
        errors++;
        $display("FAIL level: got %0d want %0d", o_level, lvl);
      end
      checks++;
      if (o_drop_count !== 16'(m_drop)) begin
        errors++;
        $display("FAIL drop_count: got %0d want %0d", o_drop_count, m_drop);
      end
      checks++;
      if (o_overflow !== m_ovf) begin
        errors++;
        $display("FAIL overflow: got %b want %b", o_overflow, m_ovf);
      end
      if (lvl != 0 && i_out_ready) begin
        e = q.pop_front();
        checks++;
        if ({o_out_pc, o_out_insn, o_out_wen, o_out_rd, o_out_wdata, o_out_exc, o_out_seq, o_out_gap} !== e) begin
          errors++;
          $display("FAIL record: got seq=%h gap=%b pc=%h insn=%h want seq=%h gap=%b pc=%h insn=%h",
                   o_out_seq, o_out_gap, o_out_pc, o_out_insn, e.seq, e.gap, e.pc, e.insn);
        end
        prev_seq = last_seq;
        last_seq = e.seq;
        last_gap = e.gap;
        popped++;
      end
      n = int'(i_c0_valid) + int'(i_c1_valid);
      if (n > 0) begin
        if (n <= 8 - lvl) begin
          a = i_c0_valid ? {i_c0_pc, i_c0_insn, i_c0_wen, i_c0_rd, i_c0_wdata, i_c0_exc, m_seq, m_gap}
                         : {i_c1_pc, i_c1_insn, i_c1_wen, i_c1_rd, i_c1_wdata, i_c1_exc, m_seq, m_gap};
          q.push_back(a);
          if (n == 2) begin
            b = {i_c1_pc, i_c1_insn, i_c1_wen, i_c1_rd, i_c1_wdata, i_c1_exc, m_seq + 16'd1, 1'b0};
            q.push_back(b);
          end
          m_gap = 1'b0;
        end else begin
          m_gap = 1'b1;
          m_ovf = 1'b1;
          m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
        end
        m_seq = m_seq + 16'(n);
      end
    end
  end
  task automatic offer(input logic v0, input logic v1);
    i_c0_valid = v0;
    i_c0_pc    = 39'({$urandom, $urandom});
    i_c0_insn  = $urandom;
    i_c0_wen   = 1'($urandom);
    i_c0_rd    = 5'($urandom);
    i_c0_wdata = {$urandom, $urandom};
    i_c0_exc   = 1'($urandom);
    i_c1_valid = v1;
    i_c1_pc    = 39'({$urandom, $urandom});
    i_c1_insn  = $urandom;
    i_c1_wen   = 1'($urandom);
    i_c1_rd    = 5'($urandom);
    i_c1_wdata = {$urandom, $urandom};
    i_c1_exc   = 1'($urandom);
  endtask
  task automatic tick(input logic rdy);
    i_out_ready = rdy;
    @(posedge clk);
    #2;
  endtask
  task automatic reset_dut();
    i_reset = 1'b0;
    offer(1'b0, 1'b0);
    tick(1'b0);
    tick(1'b0);
    i_reset = 1'b1;
  endtask
  task automatic drain();
    offer(1'b0, 1'b0);
    for (int i = 0; i < 20 && o_out_valid === 1'b1; i++) tick(1'b1);
    checks++;
    if (o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: got out_valid=%b want 0", o_out_valid);
    end
  endtask
  task automatic test_reset();
    reset_dut();
    tick(1'b0);
    checks++;
    if ({o_out_valid, o_level, o_drop_count, o_overflow} !== 22'd0) begin
      errors++;
      $display("FAIL reset_idle: got valid=%b level=%0d drops=%0d ovf=%b want all 0",
               o_out_valid, o_level, o_drop_count, o_overflow);
    end
    offer(1'b1, 1'b0);
    i_c0_pc = 39'h1000;
    tick(1'b0);
    offer(1'b0, 1'b0);
    checks++;
    if ({o_out_valid, o_out_seq, o_out_gap, o_level, o_out_pc} !== {1'b1, 16'd0, 1'b0, 4'd1, 39'h1000}) begin
      errors++;
      $display("FAIL first_commit: got valid=%b seq=%h gap=%b level=%0d pc=%h want 1 0000 0 1 1000",
               o_out_valid, o_out_seq, o_out_gap, o_level, o_out_pc);
    end
    drain();
  endtask
  task automatic test_dual_stream();
    logic [3:0] want [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
    int p0;
    reset_dut();
    p0 = popped;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 1'b1);
      tick(1'b1);
      checks++;
      if (o_level !== want[i]) begin
        errors++;
        $display("FAIL dual_level[%0d]: got %0d want %0d", i, o_level, want[i]);
      end
    end
    drain();
    checks++;
    if (popped - p0 != 8 || last_seq !== 16'd7) begin
      errors++;
      $display("FAIL dual_stream: got %0d records last seq %h want 8 records last seq 0007", popped - p0, last_seq);
    end
  endtask
  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 1'b1);
      tick(1'b0);
    end
    checks++;
    if (o_level !== 4'd8) begin
      errors++;
      $display("FAIL fill_level: got %0d want 8", o_level);
    end
    offer(1'b1, 1'b1);
    tick(1'b0);
    checks++;
    if ({o_drop_count, o_overflow, o_level} !== {16'd2, 1'b1, 4'd8}) begin
      errors++;
      $display("FAIL overflow_drop: got drops=%0d ovf=%b level=%0d want 2 1 8", o_drop_count, o_overflow, o_level);
    end
    offer(1'b0, 1'b0);
    tick(1'b1);
    offer(1'b1, 1'b0);
    tick(1'b1);
    drain();
    checks++;
    if ({last_seq, last_gap} !== {16'd10, 1'b1}) begin
      errors++;
      $display("FAIL gap_record: got seq=%0d gap=%b want seq=10 gap=1", last_seq, last_gap);
    end
  endtask
  task automatic test_no_credit();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 1'b1);
      tick(1'b0);
    end
    offer(1'b1, 1'b0);
    tick(1'b0);
    offer(1'b1, 1'b1);
    tick(1'b1);
    checks++;
    if ({o_level, o_drop_count} !== {4'd6, 16'd2}) begin
      errors++;
      $display("FAIL no_credit: got level=%0d drops=%0d want 6 2", o_level, o_drop_count);
    end
    drain();
  endtask
  task automatic test_c1_only();
    logic [15:0] s;
    logic [38:0] pc1;
    drain();
    s = m_seq;
    offer(1'b0, 1'b1);
    i_c1_insn = 32'h00000013;
    pc1 = i_c1_pc;
    tick(1'b0);
    offer(1'b0, 1'b0);
    checks++;
    if ({o_out_valid, o_out_insn, o_out_pc, o_out_seq, o_level} !== {1'b1, 32'h13, pc1, s, 4'd1}) begin
      errors++;
      $display("FAIL c1_only: got valid=%b insn=%h pc=%h seq=%h level=%0d want 1 00000013 %h %h 1",
               o_out_valid, o_out_insn, o_out_pc, o_out_seq, o_level, pc1, s);
    end
  endtask
  task automatic test_hold_reset();
    rec_t snap;
    snap = {o_out_pc, o_out_insn, o_out_wen, o_out_rd, o_out_wdata, o_out_exc, o_out_seq, o_out_gap};
    for (int i = 0; i < 5; i++) begin
      offer(1'b0, 1'b0);
      tick(1'b0);
      checks++;
      if (o_out_valid !== 1'b1 ||
          {o_out_pc, o_out_insn, o_out_wen, o_out_rd, o_out_wdata, o_out_exc, o_out_seq, o_out_gap} !== snap) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got valid=%b seq=%h pc=%h want 1 %h %h", i, o_out_valid, o_out_seq, o_out_pc, snap.seq, snap.pc);
      end
    end
    i_reset = 1'b0;
    tick(1'b0);
    i_reset = 1'b1;
    checks++;
    if ({o_out_valid, o_level} !== 5'd0) begin
      errors++;
      $display("FAIL midstream_reset: got valid=%b level=%0d want 0 0", o_out_valid, o_level);
    end
    offer(1'b1, 1'b0);
    tick(1'b0);
    checks++;
    if ({o_out_seq, o_out_gap} !== 17'd0) begin
      errors++;
      $display("FAIL seq_after_reset: got seq=%h gap=%b want 0000 0", o_out_seq, o_out_gap);
    end
    drain();
  endtask
  task automatic test_wrap_saturate();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 1'b1);
      tick(1'b0);
    end
    for (int i = 0; i < 32763; i++) begin
      offer(1'b1, 1'b1);
      tick(1'b0);
    end
    offer(1'b1, 1'b0);
    tick(1'b0);
    checks++;
    if (o_drop_count !== 16'd65527) begin
      errors++;
      $display("FAIL bulk_drops: got %0d want 65527", o_drop_count);
    end
    offer(1'b0, 1'b0);
    tick(1'b1);
    tick(1'b1);
    offer(1'b1, 1'b1);
    tick(1'b0);
    checks++;
    if (o_level !== 4'd8) begin
      errors++;
      $display("FAIL wrap_accept: got level=%0d want 8", o_level);
    end
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 1'b1);
      tick(1'b0);
    end
    checks++;
    if ({o_drop_count, o_overflow} !== {16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL saturate: got drops=%h ovf=%b want ffff 1", o_drop_count, o_overflow);
    end
    offer(1'b1, 1'b1);
    tick(1'b0);
    checks++;
    if (o_drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate_hold: got %h want ffff", o_drop_count);
    end
    drain();
    checks++;
    if ({prev_seq, last_seq} !== {16'hFFFF, 16'h0000}) begin
      errors++;
      $display("FAIL seq_wrap: got %h then %h want ffff then 0000", prev_seq, last_seq);
    end
  endtask
  initial begin
    test_reset();
    test_dual_stream();
    test_overflow();
    test_no_credit();
    test_c1_only();
    test_hold_reset();
    test_wrap_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion want finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
